// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: 32-bit fetch words in, one 16-bit inst/cycle out.
// Ports: clk, rst(async low), write/exInst/wr_ready/fetch_pc (fetch side),
//   stall/flush/flush_pc (control), inst/inst_pc/inst_valid/count (decode side).
//   PREFETCH_PERF_EN adds starve_cnt (cycles with no instruction, saturating).
module inst_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PCWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write,
  input  logic [31:0]              exInst,
  output logic                     wr_ready,
  output logic [PCWIDTH-1:0]       fetch_pc,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [PCWIDTH-1:0]       flush_pc,
  output logic [15:0]              inst,
  output logic [PCWIDTH-1:0]       inst_pc,
  output logic                     inst_valid,
`ifdef PREFETCH_PERF_EN
  output logic [15:0]              starve_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, SKIP_LO} state_t;

  state_t             state_q, state_d;
  logic [15:0]        mem_inst [DEPTH];
  logic [PCWIDTH-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count_q;
  logic [PCWIDTH-1:0] fetch_pc_q;
  logic               accept, consume;
  logic [1:0]         push_n;

  assign inst_valid = (count_q != '0);
  // conservative: ignores any same-cycle consume
  assign wr_ready   = (count_q <= CW'(DEPTH - 2));
  assign accept     = write && wr_ready && !flush;
  assign consume    = inst_valid && !stall && !flush;
  assign push_n     = !accept ? 2'd0 :
                      (state_q == SKIP_LO) ? 2'd1 : 2'd2;

  assign count    = count_q;
  assign fetch_pc = fetch_pc_q;
  assign inst     = inst_valid ? mem_inst[rd_ptr] : 16'h0000;
  assign inst_pc  = inst_valid ? mem_pc[rd_ptr] : '0;

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = flush_pc[0] ? SKIP_LO : RUN;
    else if (accept && state_q == SKIP_LO)
      state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      fetch_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= '0;
        fetch_pc_q <= {flush_pc[PCWIDTH-1:1], 1'b0};
      end else begin
        wr_ptr  <= wr_ptr + AW'(push_n);
        rd_ptr  <= rd_ptr + AW'(consume);
        count_q <= count_q + CW'(push_n) - CW'(consume);
        if (accept)
          fetch_pc_q <= fetch_pc_q + PCWIDTH'(2);
      end
    end
  end

  // payload storage needs no reset: liveness is tracked by count
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == SKIP_LO) begin
        mem_inst[wr_ptr] <= exInst[31:16];
        mem_pc[wr_ptr]   <= fetch_pc_q + PCWIDTH'(1);
      end else begin
        mem_inst[wr_ptr]          <= exInst[15:0];
        mem_pc[wr_ptr]            <= fetch_pc_q;
        mem_inst[wr_ptr + AW'(1)] <= exInst[31:16];
        mem_pc[wr_ptr + AW'(1)]   <= fetch_pc_q + PCWIDTH'(1);
      end
    end
  end

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= 16'h0000;
    else if (!inst_valid && !flush && starve_cnt != 16'hFFFF)
      starve_cnt <= starve_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue (DEPTH=4, PCWIDTH=16).
// Checks reset, latency, full/backpressure, odd flush, wrap, perf counter.
module tb_inst_prefetch_queue;

  logic        clk = 0;
  logic        rst;
  logic        write;
  logic [31:0] exInst;
  logic        wr_ready;
  logic [15:0] fetch_pc;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic [2:0]  count;
`ifdef PREFETCH_PERF_EN
  logic [15:0] starve_cnt;
`endif

  int tests = 0;
  int fails = 0;

  inst_prefetch_queue #(.DEPTH(4), .PCWIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .write(write),
    .exInst(exInst),
    .wr_ready(wr_ready),
    .fetch_pc(fetch_pc),
    .stall(stall),
    .flush(flush),
    .flush_pc(flush_pc),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
`ifdef PREFETCH_PERF_EN
    .starve_cnt(starve_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_i [4];
  logic [15:0] exp_p [4];

  initial begin
    rst = 0; write = 0; stall = 0; flush = 0;
    exInst = '0; flush_pc = '0;
    tick(); tick();
    // 1: reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_fetch_pc", 32'(fetch_pc), 0);
    chk("rst_inst", 32'(inst), 0);
    chk("rst_inst_pc", 32'(inst_pc), 0);
    rst = 1;

`ifdef PREFETCH_PERF_EN
    // 6: four idle edges, write on the fifth (still empty there)
    tick(); tick(); tick(); tick();
    chk("perf_idle4", 32'(starve_cnt), 4);
    write = 1; exInst = 32'h9999_8888; stall = 1;
    tick();
    write = 0;
    chk("perf_idle5", 32'(starve_cnt), 5);
    tick(); tick();
    chk("perf_hold", 32'(starve_cnt), 5);
    flush = 1; flush_pc = 16'h0000;
    tick();
    flush = 0; stall = 0;
`endif

    // 2: single word, latency and drain
    write = 1; exInst = {16'h0145, 16'h4001};
    tick();
    write = 0;
    chk("t2_inst0", 32'(inst), 32'h4001);
    chk("t2_pc0", 32'(inst_pc), 0);
    chk("t2_fetch_pc", 32'(fetch_pc), 2);
    chk("t2_count", 32'(count), 2);
    tick();
    chk("t2_inst1", 32'(inst), 32'h0145);
    chk("t2_pc1", 32'(inst_pc), 1);
    tick();
    chk("t2_empty", 32'(inst_valid), 0);
    chk("t2_inst_z", 32'(inst), 0);

    // 3: fill to DEPTH, ignored write, drain in order
    flush = 1; flush_pc = 16'h0000;
    tick();
    flush = 0;
    chk("t3_flush_empty", 32'(inst_valid), 0);
    stall = 1; write = 1;
    exInst = {16'h2222, 16'h1111};
    tick();
    exInst = {16'h4444, 16'h3333};
    tick();
    chk("t3_full_count", 32'(count), 4);
    chk("t3_full_ready", 32'(wr_ready), 0);
    chk("t3_full_valid", 32'(inst_valid), 1);
    exInst = {16'h6666, 16'h5555};
    tick();
    write = 0;
    chk("t3_ign_count", 32'(count), 4);
    chk("t3_ign_fpc", 32'(fetch_pc), 4);
    stall = 0;
    exp_i = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_inst%0d", i), 32'(inst), 32'(exp_i[i]));
      chk($sformatf("t3_pc%0d", i), 32'(inst_pc), i);
      tick();
    end
    chk("t3_drained", 32'(inst_valid), 0);

    // 4: odd flush with count=3 and same-cycle write
    stall = 1; write = 1;
    exInst = {16'hAA02, 16'hAA01};
    tick();
    exInst = {16'hAA04, 16'hAA03};
    tick();
    write = 0; stall = 0;
    tick();
    stall = 1;
    chk("t4_count3", 32'(count), 3);
    flush = 1; flush_pc = 16'h0007;
    write = 1; exInst = 32'h5555_5555;
    tick();
    flush = 0; write = 0;
    chk("t4_count0", 32'(count), 0);
    chk("t4_valid0", 32'(inst_valid), 0);
    chk("t4_fpc6", 32'(fetch_pc), 6);
    write = 1; exInst = {16'hC870, 16'hA801};
    tick();
    write = 0;
    chk("t4_count1", 32'(count), 1);
    chk("t4_inst", 32'(inst), 32'hC870);
    chk("t4_pc7", 32'(inst_pc), 7);
    chk("t4_fpc8", 32'(fetch_pc), 8);
    stall = 0;
    tick();
    chk("t4_empty", 32'(inst_valid), 0);

    // 5: PC wrap across 16'hFFFF
    flush = 1; flush_pc = 16'hFFFE;
    tick();
    flush = 0;
    chk("t5_fpc", 32'(fetch_pc), 32'hFFFE);
    stall = 1; write = 1;
    exInst = {16'h000B, 16'h000A};
    tick();
    exInst = {16'h000D, 16'h000C};
    tick();
    write = 0;
    chk("t5_fpc_wrap", 32'(fetch_pc), 2);
    stall = 0;
    exp_i = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    exp_p = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_inst%0d", i), 32'(inst), 32'(exp_i[i]));
      chk($sformatf("t5_pc%0d", i), 32'(inst_pc), 32'(exp_p[i]));
      tick();
    end
    chk("t5_empty", 32'(inst_valid), 0);

    // back-to-back flushes: last (even) target wins
    flush = 1; flush_pc = 16'h0003;
    tick();
    flush_pc = 16'h0008;
    tick();
    flush = 0;
    chk("b2b_fpc", 32'(fetch_pc), 8);
    write = 1; exInst = {16'h0077, 16'h0066};
    tick();
    write = 0; stall = 1;
    chk("b2b_inst", 32'(inst), 32'h0066);
    chk("b2b_pc", 32'(inst_pc), 8);
    chk("b2b_count", 32'(count), 2);

    // async reset mid-transfer drops everything
    #2 rst = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(inst_valid), 0);
    chk("arst_fpc", 32'(fetch_pc), 0);
    tick();
    rst = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
